// File: rtl/sim_uart_pkg.sv
// Shared register offsets, STATUS bit positions and TX state encoding for the
// SimTop console bridge.
package sim_uart_pkg;

  localparam logic [7:0] UART_TXDATA  = 8'h00;
  localparam logic [7:0] UART_STATUS  = 8'h04;
  localparam logic [7:0] UART_RXDATA  = 8'h08;
  localparam logic [7:0] UART_TRAP    = 8'h0C;
  localparam logic [7:0] UART_TXCOUNT = 8'h10;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_TRAP_PEND = 2;
  localparam int STAT_HALTED    = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACE   = 2'd1,
    HALTED = 2'd2
  } uart_tx_state_e;

endpackage

// File: rtl/sim_uart_fifo.sv
// Synchronous FIFO with an explicit occupancy counter; full/empty come from the
// counter so the pointers can wrap naturally at log2(DEPTH) bits.
module sim_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/sim_uart_tx_bridge.sv
// MMIO console bridge: buffers TX characters, paces emission, emits the trap marker last.
// Optional TX statistics counter at 0x10 is built when SIM_UART_TX_STATS_EN is defined.
module sim_uart_tx_bridge
  import sim_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PACE_CYCLES = 0,
  parameter int ADDR_W      = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              io_uart_out_valid,
  output logic [7:0]        io_uart_out_ch,
  output logic              io_uart_in_valid,
  input  logic [7:0]        io_uart_in_ch
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [PW-1:0] PACE_LOAD = PW'((PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0);

  uart_tx_state_e r_state;
  uart_tx_state_e w_state_nxt;

  logic [ADDR_W-1:0] w_off;
  logic              w_sel_tx, w_sel_status, w_sel_rx, w_sel_trap, w_sel_txcount;
  logic              w_accept, w_rd, w_wr;
  logic              w_push, w_pop, w_trap_wr, w_trap_emit, w_pace_load;
  logic              w_full, w_empty, w_halted;
  logic [CW-1:0]     w_count;
  logic [7:0]        w_count8;
  logic [7:0]        w_fifo_rdata;
  logic [31:0]       w_status, w_rdata, w_tx_count;
  logic              w_out_valid;
  logic [7:0]        w_out_ch;
  logic              r_trap_pending;
  logic [6:0]        r_trap_code;
  logic [PW-1:0]     r_pace_cnt;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              w_unused;

  assign w_off         = {req_addr[ADDR_W-1:2], 2'b00};
  assign w_sel_tx      = (w_off == ADDR_W'(UART_TXDATA));
  assign w_sel_status  = (w_off == ADDR_W'(UART_STATUS));
  assign w_sel_rx      = (w_off == ADDR_W'(UART_RXDATA));
  assign w_sel_trap    = (w_off == ADDR_W'(UART_TRAP));
  assign w_sel_txcount = (w_off == ADDR_W'(UART_TXCOUNT));
  assign w_unused      = ^{req_addr[1:0], req_wdata[31:7]};

  assign w_halted  = (r_state == HALTED);
  // Only a TXDATA write into a full FIFO stalls; once halted those writes are dropped anyway.
  assign req_ready = !reset && !(req_write && w_sel_tx && w_full && !w_halted);
  assign w_accept  = req_valid && req_ready;
  assign w_rd      = w_accept && !req_write;
  assign w_wr      = w_accept && req_write;
  assign w_push    = w_wr && w_sel_tx && !r_trap_pending && !w_halted;
  assign w_trap_wr = w_wr && w_sel_trap && !r_trap_pending && !w_halted;

  assign io_uart_in_valid = w_rd && w_sel_rx;

  sim_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({1'b0, req_wdata[6:0]}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_count8 = 8'(w_count);

  always_comb begin
    w_status = '0;
    w_status[STAT_EMPTY]              = w_empty;
    w_status[STAT_FULL]               = w_full;
    w_status[STAT_TRAP_PEND]          = r_trap_pending;
    w_status[STAT_HALTED]             = w_halted;
    w_status[STAT_COUNT_LSB +: 8]     = w_count8;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (w_sel_status)       w_rdata = w_status;
      else if (w_sel_rx)      w_rdata = {24'b0, io_uart_in_ch};
      else if (w_sel_txcount) w_rdata = w_tx_count;
    end
  end

`ifdef SIM_UART_TX_STATS_EN
  logic [31:0] r_tx_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_tx_count <= '0;
    else if (w_pop) r_tx_count <= r_tx_count + 32'd1;
  end
  assign w_tx_count = r_tx_count;
`else
  assign w_tx_count = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_rdata <= w_rdata;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trap_pending <= 1'b0;
      r_trap_code    <= '0;
    end else if (w_trap_wr) begin
      r_trap_pending <= 1'b1;
      r_trap_code    <= req_wdata[6:0];
    end else if (w_trap_emit) begin
      r_trap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The trap is only considered from IDLE with an empty FIFO, which keeps it behind all data.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_out_valid = 1'b0;
    w_out_ch    = '0;
    w_trap_emit = 1'b0;
    w_pace_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_out_valid = 1'b1;
          w_out_ch    = w_fifo_rdata;
          if (PACE_CYCLES > 0) begin
            w_pace_load = 1'b1;
            w_state_nxt = PACE;
          end
        end else if (r_trap_pending) begin
          w_out_valid = 1'b1;
          w_out_ch    = {1'b1, r_trap_code};
          w_trap_emit = 1'b1;
          w_state_nxt = HALTED;
        end
      end
      PACE: begin
        if (r_pace_cnt == '0) w_state_nxt = IDLE;
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 r_pace_cnt <= '0;
    else if (w_pace_load)                      r_pace_cnt <= PACE_LOAD;
    else if (r_state == PACE && r_pace_cnt != '0) r_pace_cnt <= r_pace_cnt - 1'b1;
  end

  assign io_uart_out_valid = w_out_valid;
  assign io_uart_out_ch    = w_out_ch;

endmodule
